gemm_fixed_weights: RTL and testbench
=====================================

GEMM_FIXED_WEIGHTS -- requirements
Module: gemm_fixed_weights

Interface
- REQ-001: Parameter SA_SIZE, default 2: systolic array dimension; vector length and number of output lanes.
- REQ-002: Parameter WEIGHT_ACTIVATION_SIZE, default 8: bit width of every activation, weight, partial sum and output.
- REQ-003: clk, input, 1: the single clock; all state changes on its rising edge.
- REQ-004: resetn, input, 1: asynchronous, active-low reset.
- REQ-005: activation_inputs, input, [WEIGHT_ACTIVATION_SIZE-1:0] x SA_SIZE (unpacked): input vector x, sampled on each advance.
- REQ-006: should_advance_computation, input, 1: global advance; when high at a rising edge, the whole pipeline steps once and consumes one input vector.
- REQ-007: activation_outputs, output, [WEIGHT_ACTIVATION_SIZE-1:0] x SA_SIZE (unpacked): result vector y.
- REQ-008: output_valid, output, 1: activation_outputs holds a result for a real input vector.

Function
- REQ-009: Weight-stationary SA_SIZE x SA_SIZE array; weight matrix W[j][i] is held in weights_reg and is never written after reset.
- REQ-010: Result: y[i] = sum over j of x[j]*W[j][i], truncated modulo 2^WEIGHT_ACTIVATION_SIZE; every product and accumulation wraps at that width.
- REQ-011: Streaming operation: one vector is accepted per advance, with no bubbles between consecutive vectors.
- REQ-012: Pipeline length is exactly 2*SA_SIZE advances, made up of input skew, array traversal and output deskew.
- REQ-013: After the n-th advance since reset (n >= 2*SA_SIZE), activation_outputs equals the result for the vector sampled at advance n-2*SA_SIZE+1.
- REQ-014: With should_advance_computation low, every register (skew, PE, deskew, counter) holds its value and outputs are stable.
- REQ-015: An internal advance counter saturates at 2*SA_SIZE.
- REQ-016: output_valid rises on the edge of the 2*SA_SIZE-th advance and then stays high until reset (sticky).
- REQ-017: Advances are unlimited; there is no back-pressure and no overflow condition.
- REQ-018: The pipeline carries no per-stage valid; garbage or zero data before output_valid is permitted.

Reset
- REQ-019: Assertion of resetn low asynchronously clears the counter, output_valid, all skew/PE/deskew registers and activation_outputs to 0.
- REQ-020: Reset also loads weights_reg from package constant WEIGHT_INIT.
- REQ-021: Reset mid-operation discards all in-flight vectors; counting restarts from 0 after release.

Configuration
- REQ-022: Macro GEMM_FREE_WEIGHTS_EN.
- REQ-023: With GEMM_FREE_WEIGHTS_EN defined, weights_reg has no reset and no write, so it keeps an arbitrary constant initial value for formal exploration.
- REQ-024: With GEMM_FREE_WEIGHTS_EN not defined, REQ-020 applies.

Structure
- REQ-025: Package GEMM_pkg holds the default sizes, the WEIGHT_INIT constant and the activation/weight typedef.
- REQ-026: One sub-module, systolic_array, instanced as u_SA.
- REQ-027: u_SA owns weights_reg[SA_SIZE][SA_SIZE], the PE grid and the skew/deskew registers.
- REQ-028: The weights_reg hierarchy path u_SA.weights_reg is fixed, because benches read it.

Verification
- REQ-029: W=[[3,0],[0,2]]; x=(2,5); 4 advances -> output_valid rises, outputs (6,10).
- REQ-030: Same W; then x=(3,2) on the next advance -> outputs (9,4), output_valid stays high.
- REQ-031: Advance held low for 10 cycles between advances -> outputs and output_valid frozen; the latency count is unchanged.
- REQ-032: W all 0xFF, x=(0xFF,0xFF) -> y[i]=(0x01+0x01) mod 256 = 0x02, demonstrating wrap.
- REQ-033: resetn pulsed low after 3 advances -> output_valid stays 0 until 4 further advances.
- REQ-034: Random W/x stream -> every output after valid matches the reference product of the vector sampled 2*SA_SIZE advances earlier.

Source files
------------

// File: rtl/gemm_fixed_weights_pkg.sv
// GEMM_pkg: shared sizes, element typedef and the power-on weight matrix
// for gemm_fixed_weights.
//   SA_SIZE_DEF / WEIGHT_ACTIVATION_SIZE_DEF : default array size / data width
//   act_t       : one activation / weight / partial-sum element
//   WEIGHT_INIT : W[j][i], row j = input index, column i = output lane
//   weight_init : bounds-safe lookup so other array sizes still elaborate
package GEMM_pkg;

    localparam int SA_SIZE_DEF                = 2;
    localparam int WEIGHT_ACTIVATION_SIZE_DEF = 8;

    typedef logic [WEIGHT_ACTIVATION_SIZE_DEF-1:0] act_t;

    localparam act_t WEIGHT_INIT [SA_SIZE_DEF][SA_SIZE_DEF] = '{
        '{act_t'(3), act_t'(0)},
        '{act_t'(0), act_t'(2)}
    };

    // Entries outside the default table come up as zero.
    function automatic act_t weight_init(input int j, input int i);
        act_t w;
        w = '0;
        if (j >= 0 && j < SA_SIZE_DEF && i >= 0 && i < SA_SIZE_DEF)
            w = WEIGHT_INIT[j][i];
        return w;
    endfunction

endpackage

// File: rtl/gemm_fixed_weights_systolic_array.sv
// systolic_array: weight-stationary SA_SIZE x SA_SIZE MAC grid with input
// skew and output deskew. Everything steps only when 'advance' is high.
//   clk, resetn : clock, async active-low reset
//   advance     : global pipeline step
//   act_in      : input vector x (unpacked, one element per row)
//   act_out     : result vector y (unpacked, one element per column)
// Timing: x[j] waits j stages of skew, PE[j][i] consumes it i stages later,
// column i then waits N-i deskew stages (the last one is the output
// register), giving 2*N stages end to end for every element.
// Macro GEMM_FREE_WEIGHTS_EN: weights_reg gets no reset and no write, so a
// formal tool may pick any constant initial matrix.
module systolic_array
    import GEMM_pkg::*;
#(
    parameter int SA_SIZE                = SA_SIZE_DEF,
    parameter int WEIGHT_ACTIVATION_SIZE = WEIGHT_ACTIVATION_SIZE_DEF
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              advance,
    input  logic [WEIGHT_ACTIVATION_SIZE-1:0] act_in  [SA_SIZE],
    output logic [WEIGHT_ACTIVATION_SIZE-1:0] act_out [SA_SIZE]
);

    localparam int N = SA_SIZE;
    localparam int W = WEIGHT_ACTIVATION_SIZE;

    logic [W-1:0] weights_reg [N][N];

    // act_h[j][i]: activation presented to PE[j][i] (flows right along row j)
    // psum_v[j][i]: partial sum entering PE[j][i] (flows down column i)
    logic [W-1:0] act_h  [N][N];
    logic [W-1:0] psum_v [N+1][N];

`ifdef GEMM_FREE_WEIGHTS_EN
    always_ff @(posedge clk)
        weights_reg <= weights_reg;
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < N; j++)
                for (int i = 0; i < N; i++)
                    weights_reg[j][i] <= W'(weight_init(j, i));
        end else begin
            weights_reg <= weights_reg;
        end
    end
`endif

    // Input skew: row j delayed by j stages so the wavefront meets the
    // partial sum coming down from the row above.
    for (genvar j = 0; j < N; j++) begin : g_skew
        if (j == 0) begin : g_pass
            assign act_h[j][0] = act_in[j];
        end else begin : g_dly
            logic [W-1:0] sr [j];
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int s = 0; s < j; s++) sr[s] <= '0;
                end else if (advance) begin
                    sr[0] <= act_in[j];
                    for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
                end
            end
            assign act_h[j][0] = sr[j-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_psum_top
        assign psum_v[0][i] = '0;
    end

    // PE grid; products and sums wrap at W bits by construction.
    for (genvar j = 0; j < N; j++) begin : g_row
        for (genvar i = 0; i < N; i++) begin : g_pe
            logic [W-1:0] p_q;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)      p_q <= '0;
                else if (advance) p_q <= psum_v[j][i] + act_h[j][i] * weights_reg[j][i];
            end
            assign psum_v[j+1][i] = p_q;

            if (i < N-1) begin : g_fwd
                logic [W-1:0] a_q;
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn)      a_q <= '0;
                    else if (advance) a_q <= act_h[j][i];
                end
                assign act_h[j][i+1] = a_q;
            end
        end
    end

    // Output deskew: column i waits N-i stages; last stage drives act_out.
    for (genvar i = 0; i < N; i++) begin : g_deskew
        logic [W-1:0] sr [N-i];
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                for (int s = 0; s < N-i; s++) sr[s] <= '0;
            end else if (advance) begin
                sr[0] <= psum_v[N][i];
                for (int s = 1; s < N-i; s++) sr[s] <= sr[s-1];
            end
        end
        assign act_out[i] = sr[N-i-1];
    end

endmodule

// File: rtl/gemm_fixed_weights.sv
// gemm_fixed_weights: streaming y = x * W with a weight-stationary
// systolic array; one vector per advance, 2*SA_SIZE advances of latency.
//   clk, resetn                : clock, async active-low reset
//   activation_inputs          : input vector x
//   should_advance_computation : global pipeline step, no back-pressure
//   activation_outputs         : result vector y
//   output_valid               : sticky, set on the 2*SA_SIZE-th advance
// Macro GEMM_FREE_WEIGHTS_EN: leaves weights unreset for formal exploration.
module gemm_fixed_weights
    import GEMM_pkg::*;
#(
    parameter int SA_SIZE                = SA_SIZE_DEF,
    parameter int WEIGHT_ACTIVATION_SIZE = WEIGHT_ACTIVATION_SIZE_DEF
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_inputs  [SA_SIZE],
    input  logic                              should_advance_computation,
    output logic [WEIGHT_ACTIVATION_SIZE-1:0] activation_outputs [SA_SIZE],
    output logic                              output_valid
);

    localparam int               CNT_W = $clog2(2*SA_SIZE + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(2*SA_SIZE);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(2*SA_SIZE - 1);

    logic [CNT_W-1:0] adv_cnt;

    // Counter only needs to reach the pipeline depth; it saturates there.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adv_cnt      <= '0;
            output_valid <= 1'b0;
        end else if (should_advance_computation && adv_cnt != FULL) begin
            adv_cnt <= adv_cnt + CNT_W'(1);
            if (adv_cnt == LAST) output_valid <= 1'b1;
        end
    end

    systolic_array #(
        .SA_SIZE                (SA_SIZE),
        .WEIGHT_ACTIVATION_SIZE (WEIGHT_ACTIVATION_SIZE)
    ) u_SA (
        .clk     (clk),
        .resetn  (resetn),
        .advance (should_advance_computation),
        .act_in  (activation_inputs),
        .act_out (activation_outputs)
    );

endmodule

// File: tb/tb_gemm_fixed_weights.sv
// Bench for gemm_fixed_weights: directed cases plus a random stream, all
// checked against a queue-based reference of y[i] = sum_j x[j]*W[j][i].
module tb_gemm_fixed_weights;
    import GEMM_pkg::*;

    localparam int N = SA_SIZE_DEF;
    localparam int W = WEIGHT_ACTIVATION_SIZE_DEF;

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] x [N];
    logic         go;
    logic [W-1:0] y [N];
    logic         vld;

    int n_chk = 0;
    int n_err = 0;

    logic [N*W-1:0] hist [$];   // last 2*N vectors accepted
    int             nadv;

    always #5 clk = ~clk;

    gemm_fixed_weights #(.SA_SIZE(N), .WEIGHT_ACTIVATION_SIZE(W)) dut (
        .clk                        (clk),
        .resetn                     (resetn),
        .activation_inputs          (x),
        .should_advance_computation (go),
        .activation_outputs         (y),
        .output_valid               (vld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_y(input logic [N*W-1:0] xv, input int i);
        int acc = 0;
        for (int j = 0; j < N; j++)
            acc += int'(xv[j*W +: W]) * int'(WEIGHT_INIT[j][i]);
        return W'(acc);
    endfunction

    task automatic check_state(input string tag);
        bit ev = (nadv >= 2*N);
        chk({tag, ".valid"}, 32'(vld), 32'(ev));
        if (ev)
            for (int i = 0; i < N; i++)
                chk($sformatf("%s.y%0d", tag, i), 32'(y[i]), 32'(ref_y(hist[0], i)));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string tag, input bit adv, input logic [N*W-1:0] xv);
        for (int i = 0; i < N; i++) x[i] = xv[i*W +: W];
        go = adv;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        if (adv) begin
            hist.push_back(xv);
            if (hist.size() > 2*N) void'(hist.pop_front());
            if (nadv < 2*N) nadv++;
        end
        check_state(tag);
    endtask

    function automatic logic [N*W-1:0] vec2(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [N*W-1:0] v = '0;
        v[0 +: W] = a;
        v[W +: W] = b;
        return v;
    endfunction

    function automatic logic [N*W-1:0] rnd_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        hist.delete();
        nadv = 0;
        chk({tag, ".valid"}, 32'(vld), 32'd0);
        for (int i = 0; i < N; i++) chk($sformatf("%s.y%0d", tag, i), 32'(y[i]), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        go     = 1'b0;
        for (int i = 0; i < N; i++) x[i] = '0;
        nadv = 0;
        repeat (2) @(negedge clk);
        chk("rst.valid", 32'(vld), 32'd0);
        for (int i = 0; i < N; i++) chk($sformatf("rst.y%0d", i), 32'(y[i]), 32'd0);
        resetn = 1'b1;

        // Constant vector (2,5): valid on the 4th advance with (6,10).
        for (int k = 0; k < 4; k++) step("const", 1'b1, vec2(8'd2, 8'd5));
        chk("const.y0_abs", 32'(y[0]), 32'd6);
        chk("const.y1_abs", 32'(y[1]), 32'd10);

        // New vector (3,2) streams in behind without bubbles.
        for (int k = 0; k < 4; k++) step("next", 1'b1, vec2(8'd3, 8'd2));
        chk("next.y0_abs", 32'(y[0]), 32'd9);
        chk("next.y1_abs", 32'(y[1]), 32'd4);

        // Stall: inputs wiggle but nothing may move.
        step("mix", 1'b1, vec2(8'd7, 8'd1));
        for (int k = 0; k < 10; k++) step("hold", 1'b0, rnd_vec());
        for (int k = 0; k < 4; k++) step("resume", 1'b1, rnd_vec());

        // Wrap: 0xFF*3 -> 0xFD, 0x80*2 -> 0x00, 0xFF*2 -> 0xFE.
        for (int k = 0; k < 4; k++) step("wrap", 1'b1, vec2(8'hFF, 8'h80));
        chk("wrap.y0_abs", 32'(y[0]), 32'h0FD);
        chk("wrap.y1_abs", 32'(y[1]), 32'h000);
        for (int k = 0; k < 4; k++) step("wrap2", 1'b1, vec2(8'hFF, 8'hFF));
        chk("wrap2.y1_abs", 32'(y[1]), 32'h0FE);

        // Reset mid-stream after 3 advances of a fresh run.
        async_reset("mrst0");
        for (int k = 0; k < 3; k++) step("pre", 1'b1, rnd_vec());
        async_reset("mrst");
        for (int k = 0; k < 4; k++) step("post", 1'b1, rnd_vec());

        // Random stream with random stalls.
        for (int k = 0; k < 300; k++)
            step("rand", ($urandom_range(0, 3) != 0), rnd_vec());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
